// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM,
        OWN_DBG
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_IF  = 0;
    localparam int GNT_DM  = 1;
    localparam int GNT_DBG = 2;

endpackage

// File: rtl/mem_arb_prio_sel.sv
// Combinational priority picker: DBG > DM > IF, or DBG > IF > DM while starving.
module mem_arb_prio_sel
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       dbg_req,
    input  logic       starve,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (dbg_req) begin
            gnt[GNT_DBG] = 1'b1;
        end else if (starve && if_req) begin
            gnt[GNT_IF] = 1'b1;
        end else if (dm_req) begin
            gnt[GNT_DM] = 1'b1;
        end else if (if_req) begin
            gnt[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, load/store and debug reads, steering
// one-cycle-latency read data back to the requester that issued the read.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    input  logic                dbg_req_i,
    input  logic [ADDR_W-1:0]   dbg_addr_i,
    output logic                dbg_gnt_o,
    output logic                dbg_rvalid_o,
    output logic [DATA_W-1:0]   dbg_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q;
    logic          starve;
    logic [2:0]    gnt_raw;
    logic [2:0]    gnt;
    owner_e        owner_q;
    owner_e        owner_d;

    assign starve = (starve_q == SW'(STARVE_MAX));

    mem_arb_prio_sel u_prio_sel (
        .if_req  (if_req_i),
        .dm_req  (dm_req_i),
        .dbg_req (dbg_req_i),
        .starve  (starve),
        .gnt     (gnt_raw)
    );

    // Reset masks every grant so nothing reaches the memory while in reset.
    assign gnt       = gnt_raw & {3{~rst_i}};
    assign if_gnt_o  = gnt[GNT_IF];
    assign dm_gnt_o  = gnt[GNT_DM];
    assign dbg_gnt_o = gnt[GNT_DBG];
    assign mem_req_o = |gnt;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = {BE_W{1'b1}};
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt[GNT_DBG]) begin
            mem_addr_o = dbg_addr_i;
        end else if (gnt[GNT_DM]) begin
            mem_we_o    = dm_we_i;
            mem_be_o    = dm_be_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
        end else if (gnt[GNT_IF]) begin
            mem_addr_o = if_addr_i;
        end
    end

    // Writes complete at grant, so only read grants claim the return slot.
    always_comb begin
        owner_d = OWN_NONE;
        if (gnt[GNT_DBG]) begin
            owner_d = OWN_DBG;
        end else if (gnt[GNT_DM] && !dm_we_i) begin
            owner_d = OWN_DM;
        end else if (gnt[GNT_IF]) begin
            owner_d = OWN_IF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
            if (!if_req_i || gnt[GNT_IF]) begin
                starve_q <= '0;
            end else if (gnt[GNT_DM] && !starve) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

    // A read granted just before reset is dropped rather than returned.
    assign if_rvalid_o  = (owner_q == OWN_IF)  && !rst_i;
    assign dm_rvalid_o  = (owner_q == OWN_DM)  && !rst_i;
    assign dbg_rvalid_o = (owner_q == OWN_DBG) && !rst_i;

    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;
    assign dbg_rdata_o = mem_rdata_i;

endmodule
